// File: rtl/produttore.sv
// Producer end of the dav_/rfd four-phase handshake: emits len words base, base+1, ...
// Optional WAIT_ACK timeout enabled by defining PRODUTTORE_TIMEOUT_EN.
module produttore #(
  parameter int TMO_MAX = 255
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       start,
  input  logic [7:0] base,
  input  logic [7:0] len,
  input  logic       rfd,
  output logic       dav_,
  output logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] dbg_state
);

  // Handshake per word: data is set up while dav_=1, dav_ falls once rfd=1 is seen,
  // the consumer takes the word by dropping rfd, dav_ rises, and the next word waits for rfd=1.
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_RFD} state_t;

  state_t     state, state_nx;
  logic       dav_nx;
  logic [7:0] data_nx;
  logic [7:0] rem, rem_nx;
  logic       busy_nx;
  logic       done_nx;

`ifdef PRODUTTORE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_MAX + 1);
  logic             err_r, err_nx;
  logic [TMO_W-1:0] tmo, tmo_nx;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      dav_  <= 1'b1;
      data  <= 8'd0;
      rem   <= 8'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef PRODUTTORE_TIMEOUT_EN
      err_r <= 1'b0;
      tmo   <= '0;
`endif
    end else begin
      state <= state_nx;
      dav_  <= dav_nx;
      data  <= data_nx;
      rem   <= rem_nx;
      busy  <= busy_nx;
      done  <= done_nx;
`ifdef PRODUTTORE_TIMEOUT_EN
      err_r <= err_nx;
      tmo   <= tmo_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    dav_nx   = dav_;
    data_nx  = data;
    rem_nx   = rem;
    busy_nx  = busy;
    done_nx  = 1'b0;
`ifdef PRODUTTORE_TIMEOUT_EN
    err_nx   = err_r;
    tmo_nx   = tmo;
`endif
    case (state)
      IDLE: begin
        dav_nx  = 1'b1;
        busy_nx = 1'b0;
        if (start) begin
`ifdef PRODUTTORE_TIMEOUT_EN
          err_nx = 1'b0;
`endif
          if (len != 8'd0) begin
            data_nx  = base;
            rem_nx   = len;
            busy_nx  = 1'b1;
            state_nx = SETUP;
          end else begin
            // Empty burst completes immediately without touching the bus.
            done_nx = 1'b1;
          end
        end
      end
      SETUP: begin
        if (rfd) begin
          dav_nx   = 1'b0;
          state_nx = WAIT_ACK;
`ifdef PRODUTTORE_TIMEOUT_EN
          tmo_nx   = '0;
`endif
        end
      end
      WAIT_ACK: begin
        if (!rfd) begin
          dav_nx   = 1'b1;
          rem_nx   = rem - 8'd1;
          state_nx = WAIT_RFD;
        end
`ifdef PRODUTTORE_TIMEOUT_EN
        else if (tmo == TMO_W'(TMO_MAX - 1)) begin
          // Consumer never took the word: abandon the burst without a done pulse.
          dav_nx   = 1'b1;
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          rem_nx   = 8'd0;
          state_nx = IDLE;
        end else begin
          tmo_nx = tmo + TMO_W'(1);
        end
`endif
      end
      WAIT_RFD: begin
        if (rfd) begin
          if (rem == 8'd0) begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            data_nx  = data + 8'd1;
            state_nx = SETUP;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_produttore.sv
// Bench for produttore: directed and random bursts against a queue of expected words.
module tb_produttore;
  localparam int TMO_MAX = 255;

  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base = 8'd0;
  logic [7:0] len = 8'd0;
  logic       rfd = 1'b1;
  logic       dav_;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int falls = 0;
  int dones = 0;
  logic [7:0] exp_q[$];

  produttore #(.TMO_MAX(TMO_MAX)) dut (
    .clock(clock), .reset_(reset_), .start(start), .base(base), .len(len),
    .rfd(rfd), .dav_(dav_), .data(data), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge dav_) if (reset_) falls++;

  always @(negedge clock) begin
    if (done === 1'b1) begin
      dones++;
      chk("done_busy_excl", busy, 0);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_burst(input logic [7:0] b, input logic [7:0] l);
    for (int i = 0; i < int'(l); i++) exp_q.push_back(b + 8'(i));
    base  = b;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, (l != 8'd0));
    if (l != 8'd0) chk("start_data", data, b);
    else begin
      chk("zero_done", done, 1);
      chk("zero_dav", dav_, 1);
    end
  endtask

  task automatic consume(input int n, input int setup_wait, input int ack_wait,
                         input int gap_wait, input bit poke);
    logic [7:0] prev, w;
    int t;
    for (int k = 0; k < n; k++) begin
      rfd = 1'b0;
      for (int c = 0; c < ((k == 0) ? setup_wait : gap_wait); c++) begin
        prev = data;
        tick();
        chk("hold_dav", dav_, 1);
        chk("hold_data", data, prev);
      end
      rfd  = 1'b1;
      t    = 0;
      prev = data;
      while (dav_ !== 1'b0 && t < 8) begin
        prev = data;
        tick();
        t++;
      end
      chk("dav_fall", dav_, 0);
      chk("queue_nonempty", (exp_q.size() != 0), 1);
      w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      chk("word", data, w);
      chk("word_setup_stable", data, prev);
      if (poke && k == 0) begin
        base  = 8'h80;
        len   = 8'd5;
        start = 1'b1;
      end
      for (int c = 0; c < ack_wait; c++) begin
        tick();
        chk("ack_hold_dav", dav_, 0);
        chk("ack_hold_data", data, w);
      end
      rfd = 1'b0;
      t   = 0;
      while (dav_ !== 1'b1 && t < 8) begin
        tick();
        t++;
      end
      start = 1'b0;
      chk("dav_rise", dav_, 1);
      chk("rise_data", data, w);
    end
    for (int c = 0; c < gap_wait; c++) begin
      tick();
      chk("tail_no_done", done, 0);
      chk("tail_busy", busy, 1);
    end
    rfd = 1'b1;
    tick();
    chk("done_pulse", done, 1);
    chk("end_busy", busy, 0);
    chk("end_dav", dav_, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int f0, d0, t;
    logic [7:0] b, l;

    reset_ = 1'b0;
    repeat (3) tick();
    chk("rst_dav", dav_, 1);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, 0);
    reset_ = 1'b1;
    tick();

    // Single burst with a prompt consumer
    f0 = falls; d0 = dones;
    start_burst(8'h10, 8'd3);
    consume(3, 0, 0, 0, 1'b0);
    chk("single_falls", falls - f0, 3);
    chk("single_dones", dones - d0, 1);

    // Wrap-around then empty burst
    f0 = falls;
    start_burst(8'hFE, 8'd3);
    consume(3, 1, 1, 1, 1'b0);
    chk("wrap_falls", falls - f0, 3);
    f0 = falls;
    start_burst(8'h55, 8'd0);
    tick();
    chk("zero_done_off", done, 0);
    chk("zero_busy", busy, 0);
    chk("zero_falls", falls - f0, 0);

    // Slow consumer
    f0 = falls;
    start_burst(8'h40, 8'd3);
    consume(3, 5, 0, 4, 1'b0);
    chk("slow_falls", falls - f0, 3);

    // Start while busy is ignored
    f0 = falls; d0 = dones;
    start_burst(8'h20, 8'd2);
    consume(2, 0, 1, 0, 1'b1);
    chk("poke_falls", falls - f0, 2);
    chk("poke_dones", dones - d0, 1);

    // Random bursts
    repeat (10) begin
      b  = 8'($urandom);
      l  = 8'($urandom_range(0, 6));
      f0 = falls;
      start_burst(b, l);
      if (l != 8'd0) consume(int'(l), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else tick();
      chk("rand_falls", falls - f0, int'(l));
    end

    // Asynchronous reset in WAIT_ACK
    start_burst(8'h33, 8'd4);
    rfd = 1'b1;
    t = 0;
    while (dav_ !== 1'b0 && t < 8) begin
      tick();
      t++;
    end
    chk("pre_reset_dav", dav_, 0);
    #2 reset_ = 1'b0;
    #1;
    chk("mid_rst_dav", dav_, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    tick();
    reset_ = 1'b1;
    tick();
    start_burst(8'h90, 8'd1);
    consume(1, 0, 0, 0, 1'b0);

`ifdef PRODUTTORE_TIMEOUT_EN
    d0 = dones;
    start_burst(8'h61, 8'd2);
    rfd = 1'b1;
    t = 0;
    while (dav_ !== 1'b0 && t < 8) begin
      tick();
      t++;
    end
    chk("tmo_fall", dav_, 0);
    t = 0;
    while (dav_ === 1'b0 && t < 300) begin
      tick();
      t++;
    end
    chk("tmo_cycles", t, TMO_MAX);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    tick();
    chk("tmo_no_done", dones - d0, 0);
    exp_q.delete();
    start_burst(8'h70, 8'd0);
    chk("tmo_err_clear", err, 0);
    tick();
`else
    // Consumer holds rfd high for 1000 cycles: no timeout exists
    start_burst(8'h61, 8'd1);
    consume(1, 0, 1000, 0, 1'b0);
    chk("no_tmo_err", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
